// File: rtl/cache_bus2_master.sv
// Cache-side master for bus 2: turns one line request into a C2/A2/D2 burst of
// 16-bit beats to the memory controller and returns a single completion.
module cache_bus2_master #(
    parameter int ADDR_W         = 15,
    parameter int BEATS          = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [127:0]      req_wdata,
    output logic              resp_valid,
    output logic [127:0]      resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] A2,
    inout  wire  [15:0]       D2,
    inout  wire  [1:0]        C2
);
    localparam int BCNT_W = $clog2(BEATS);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] CMD_RESP = 2'd1;
    localparam logic [1:0] CMD_RD   = 2'd2;
    localparam logic [1:0] CMD_WR   = 2'd3;

    typedef enum logic [3:0] {
        IDLE, RD_CMD, RD_TURN, RD_WAIT, RD_DATA, WR_BEAT, WR_TURN, WR_WAIT, DONE
    } state_t;

    state_t              state, state_nxt;
    logic [BCNT_W-1:0]   beat_cnt;
    logic [TCNT_W-1:0]   tmo_cnt;
    logic [127:0]        line, line_cap;
    logic [BCNT_W+3:0]   beat_lsb;
    logic                accept, rsp, last_beat, tmo_hit, err_nxt, rd_done;
    logic                c2_oe, d2_oe;
    logic [1:0]          c2_out;
    logic [15:0]         d2_out;

    // Byte 2i travels on D2[15:8], byte 2i+1 on D2[7:0]; the swap is its own inverse.
    function automatic logic [15:0] beat_swap(input logic [15:0] b);
        return {b[7:0], b[15:8]};
    endfunction

    assign accept    = req_valid && req_ready;
    assign rsp       = (C2 == CMD_RESP);
    assign last_beat = (beat_cnt == BCNT_W'(BEATS - 1));
    assign tmo_hit   = (tmo_cnt == TCNT_W'(TIMEOUT_CYCLES - 1));
    assign beat_lsb  = {beat_cnt, 4'b0000};
    assign rd_done   = (state_nxt == DONE) && (state == RD_WAIT || state == RD_DATA);

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);

    assign C2 = c2_oe ? c2_out : 2'bzz;
    assign D2 = d2_oe ? d2_out : 16'hzzzz;

    always_comb begin
        line_cap = line;
        line_cap[beat_lsb +: 16] = beat_swap(D2);
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        c2_oe     = 1'b0;
        c2_out    = 2'd0;
        d2_oe     = 1'b0;
        d2_out    = 16'd0;
        case (state)
            IDLE:    if (accept) state_nxt = req_write ? WR_BEAT : RD_CMD;
            RD_CMD: begin
                c2_oe     = 1'b1;
                c2_out    = CMD_RD;
                state_nxt = RD_TURN;
            end
            RD_TURN: state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (rsp) begin
                    state_nxt = RD_DATA;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
            end
            RD_DATA: begin
                if (!rsp) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end else if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            WR_BEAT: begin
                c2_oe  = 1'b1;
                c2_out = CMD_WR;
                d2_oe  = 1'b1;
                d2_out = beat_swap(line[beat_lsb +: 16]);
                if (last_beat) state_nxt = WR_TURN;
            end
            WR_TURN: state_nxt = WR_WAIT;
            WR_WAIT: begin
                if (rsp) begin
                    state_nxt = DONE;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            tmo_cnt    <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            A2         <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                A2       <= req_addr;
                beat_cnt <= '0;
            end
            if (state == RD_TURN || state == WR_TURN)
                tmo_cnt <= '0;
            else if (state == RD_WAIT || state == WR_WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (state == WR_BEAT || ((state == RD_WAIT || state == RD_DATA) && rsp))
                beat_cnt <= beat_cnt + 1'b1;
            if (state_nxt == DONE)
                resp_err <= err_nxt;
            // Failed reads return an all-zero line rather than partial data.
            if (rd_done)
                resp_rdata <= err_nxt ? '0 : line_cap;
        end
    end

    // Line buffer: write data at acceptance, read beats as they arrive.
    always_ff @(posedge clk) begin
        if (accept)
            line <= req_wdata;
        else if ((state == RD_WAIT || state == RD_DATA) && rsp)
            line <= line_cap;
    end
endmodule
